// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: E->C registers, data memory request FSM, load alignment.
package mem_stage_pkg;
  typedef enum logic [1:0] {FROM_ALU = 2'd0, FROM_CACHE = 2'd1, FROM_PC4 = 2'd2} result_src_e;
  typedef enum logic {SIZE_B = 1'b0, SIZE_W = 1'b1} data_size_e;
  typedef enum logic [1:0] {NO_XCPT = 2'd0, INSTR_UNALIGNED = 2'd1, ILLEGAL_INSTR = 2'd2,
                            MEM_UNALIGNED = 2'd3} xcpt_e;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic [XLEN-1:0]     alu_res_in,
  input  logic [XLEN-1:0]     write_data_in,
  input  logic [XLEN-1:0]     pc_plus4_in,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic                reg_write_in,
  input  result_src_e         result_src_in,
  input  logic                mem_write_in,
  input  data_size_e          data_size_in,
  input  xcpt_e               xcpt_in,
  input  logic                valid_in,
  output logic                mem_req_valid,
  output logic [XLEN-1:0]     mem_req_addr,
  output logic                mem_req_we,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [3:0]          mem_req_be,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_rdata,
  output logic [XLEN-1:0]     alu_res_C_out,
  output logic [XLEN-1:0]     read_data_out,
  output logic [XLEN-1:0]     pc_plus4_out,
  output logic [REG_BITS-1:0] rd_out,
  output logic                reg_write_out,
  output result_src_e         result_src_out,
  output xcpt_e               xcpt_out,
  output logic                valid_out,
  output logic                stall_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [XLEN-1:0]       r_alu_res;
  logic [XLEN-1:0]       r_write_data;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [REG_BITS-1:0]   r_rd;
  logic                  r_reg_write;
  result_src_e           r_result_src;
  logic                  r_mem_write;
  data_size_e            r_data_size;
  xcpt_e                 r_xcpt;
  logic                  r_valid;
  logic                  r_done;
  logic [XLEN-1:0]       r_read_data;

  logic                  w_load;
  logic                  w_mem_op;
  logic                  w_req_valid;
  logic                  w_complete;
  logic [7:0]            w_byte;
  logic [XLEN-1:0]       w_load_val;

  assign w_load   = ~stall_in & ~stall_out;
  assign w_mem_op = r_valid & (r_xcpt == NO_XCPT) & (r_mem_write | (r_result_src == FROM_CACHE));
  assign w_complete = w_req_valid & mem_resp_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_res    <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_result_src <= FROM_ALU;
      r_mem_write  <= 1'b0;
      r_data_size  <= SIZE_B;
      r_xcpt       <= NO_XCPT;
      r_valid      <= 1'b0;
    end else if (flush_in) begin
      r_alu_res    <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_result_src <= FROM_ALU;
      r_mem_write  <= 1'b0;
      r_data_size  <= SIZE_B;
      r_xcpt       <= NO_XCPT;
      r_valid      <= 1'b0;
    end else if (w_load) begin
      r_alu_res    <= alu_res_in;
      r_write_data <= write_data_in;
      r_pc_plus4   <= pc_plus4_in;
      r_rd         <= rd_in;
      r_reg_write  <= reg_write_in;
      r_result_src <= result_src_in;
      r_mem_write  <= mem_write_in;
      r_data_size  <= data_size_in;
      r_xcpt       <= xcpt_in;
      r_valid      <= valid_in;
    end
  end

  // A fresh instruction (load or clear) must always issue, so clearing beats setting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (flush_in | w_load) begin
      r_done <= 1'b0;
    end else if (w_complete) begin
      r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_valid = w_mem_op & ~r_done;
        if (w_req_valid & ~mem_resp_valid & ~flush_in) w_state_nxt = BUSY;
      end
      BUSY: begin
        w_req_valid = 1'b1;
        if (mem_resp_valid)  w_state_nxt = IDLE;
        else if (flush_in)   w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (mem_resp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_byte = mem_resp_rdata[7:0];
    case (r_alu_res[1:0])
      2'd0: w_byte = mem_resp_rdata[7:0];
      2'd1: w_byte = mem_resp_rdata[15:8];
      2'd2: w_byte = mem_resp_rdata[23:16];
      2'd3: w_byte = mem_resp_rdata[31:24];
      default: w_byte = mem_resp_rdata[7:0];
    endcase
  end

  assign w_load_val = (r_data_size == SIZE_W) ? mem_resp_rdata : {{(XLEN-8){w_byte[7]}}, w_byte};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_data <= '0;
    end else if (w_complete & ~r_mem_write & (r_result_src == FROM_CACHE)) begin
      r_read_data <= w_load_val;
    end
  end

  assign mem_req_valid  = w_req_valid;
  assign mem_req_addr   = r_alu_res;
  assign mem_req_we     = r_mem_write;
  assign mem_req_be     = (r_data_size == SIZE_W) ? 4'b1111 : (4'b0001 << r_alu_res[1:0]);
  assign mem_req_wdata  = (r_data_size == SIZE_W) ? r_write_data : {(XLEN/8){r_write_data[7:0]}};
  assign stall_out      = (w_req_valid & ~mem_resp_valid) | (r_state == DRAIN);

  assign alu_res_C_out  = r_alu_res;
  assign read_data_out  = r_read_data;
  assign pc_plus4_out   = r_pc_plus4;
  assign rd_out         = r_rd;
  assign reg_write_out  = r_reg_write & (r_xcpt == NO_XCPT);
  assign result_src_out = r_result_src;
  assign xcpt_out       = r_xcpt;
  assign valid_out      = r_valid;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, flush_in;
  logic [31:0] alu_res_in, write_data_in, pc_plus4_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_write_in, valid_in;
  result_src_e result_src_in;
  data_size_e  data_size_in;
  xcpt_e       xcpt_in;
  logic        mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [31:0] alu_res_C_out, read_data_out, pc_plus4_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, valid_out, stall_out;
  result_src_e result_src_out;
  xcpt_e       xcpt_out;

  int total = 0;
  int passed = 0;
  int hs = 0;

  mem_stage #(.XLEN(32), .REG_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
    .alu_res_in(alu_res_in), .write_data_in(write_data_in), .pc_plus4_in(pc_plus4_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .result_src_in(result_src_in),
    .mem_write_in(mem_write_in), .data_size_in(data_size_in), .xcpt_in(xcpt_in),
    .valid_in(valid_in), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .alu_res_C_out(alu_res_C_out), .read_data_out(read_data_out), .pc_plus4_out(pc_plus4_out),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .result_src_out(result_src_out),
    .xcpt_out(xcpt_out), .valid_out(valid_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    if (mem_req_valid === 1'b1 && mem_resp_valid === 1'b1) hs++;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    alu_res_in = '0; write_data_in = '0; pc_plus4_in = '0; rd_in = '0;
    reg_write_in = 1'b0; result_src_in = FROM_ALU; mem_write_in = 1'b0;
    data_size_in = SIZE_B; xcpt_in = NO_XCPT; valid_in = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input result_src_e src, input logic mw,
                       input data_size_e sz, input xcpt_e xc);
    alu_res_in = addr; write_data_in = wd; pc_plus4_in = 32'h0000_0104; rd_in = rd;
    reg_write_in = rw; result_src_in = src; mem_write_in = mw;
    data_size_in = sz; xcpt_in = xc; valid_in = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    clear_in();
    #3;
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_read_data", read_data_out, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;

    // word load, two wait cycles
    issue(32'h0000_1004, 32'd0, 5'd5, 1'b1, FROM_CACHE, 1'b0, SIZE_W, NO_XCPT);
    step();
    clear_in();
    #1;
    chk("wl_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("wl_addr", mem_req_addr, 32'h0000_1004);
    chk("wl_be", {28'd0, mem_req_be}, 32'hF);
    chk("wl_we", {31'd0, mem_req_we}, 32'd0);
    chk("wl_rd", {27'd0, rd_out}, 32'd5);
    chk("wl_reg_write", {31'd0, reg_write_out}, 32'd1);
    chk("wl_src", {30'd0, result_src_out}, 32'd1);
    chk("wl_stall1", {31'd0, stall_out}, 32'd1);
    step();
    chk("wl_stall2", {31'd0, stall_out}, 32'd1);
    chk("wl_req_hold", mem_req_addr, 32'h0000_1004);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("wl_stall3", {31'd0, stall_out}, 32'd0);
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #1;
    chk("wl_read_data", read_data_out, 32'hDEAD_BEEF);
    chk("wl_handshakes", hs, 32'd1);
    chk("wl_req_done", {31'd0, mem_req_valid}, 32'd0);

    // byte store, zero wait
    hs = 0;
    issue(32'h0000_1003, 32'h0000_00A5, 5'd0, 1'b0, FROM_ALU, 1'b1, SIZE_B, NO_XCPT);
    step();
    clear_in();
    mem_resp_valid = 1'b1;
    #1;
    chk("bs_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("bs_be", {28'd0, mem_req_be}, 32'h8);
    chk("bs_wdata", mem_req_wdata, 32'hA5A5_A5A5);
    chk("bs_we", {31'd0, mem_req_we}, 32'd1);
    chk("bs_stall", {31'd0, stall_out}, 32'd0);
    step();
    mem_resp_valid = 1'b0;
    #1;
    chk("bs_stall_after", {31'd0, stall_out}, 32'd0);
    chk("bs_handshakes", hs, 32'd1);
    chk("bs_read_kept", read_data_out, 32'hDEAD_BEEF);

    // byte load with sign extension
    issue(32'h0000_1001, 32'd0, 5'd7, 1'b1, FROM_CACHE, 1'b0, SIZE_B, NO_XCPT);
    step();
    clear_in();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_8000;
    #1;
    chk("bl_be", {28'd0, mem_req_be}, 32'h2);
    chk("bl_stall", {31'd0, stall_out}, 32'd0);
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #1;
    chk("bl_read_data", read_data_out, 32'hFFFF_FF80);

    // load carrying an exception
    issue(32'h0000_1002, 32'd0, 5'd9, 1'b1, FROM_CACHE, 1'b0, SIZE_W, MEM_UNALIGNED);
    step();
    clear_in();
    #1;
    chk("xc_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("xc_reg_write", {31'd0, reg_write_out}, 32'd0);
    chk("xc_xcpt", {30'd0, xcpt_out}, 32'd3);
    chk("xc_valid", {31'd0, valid_out}, 32'd1);
    chk("xc_stall", {31'd0, stall_out}, 32'd0);
    step();

    // flush while BUSY, response three cycles later is discarded
    issue(32'h0000_2000, 32'd0, 5'd3, 1'b1, FROM_CACHE, 1'b0, SIZE_W, NO_XCPT);
    step();
    clear_in();
    #1;
    chk("fl_stall_idle", {31'd0, stall_out}, 32'd1);
    step();
    flush_in = 1'b1;
    #1;
    chk("fl_busy_req", {31'd0, mem_req_valid}, 32'd1);
    step();
    flush_in = 1'b0;
    #1;
    chk("fl_valid_out", {31'd0, valid_out}, 32'd0);
    chk("fl_drain_req", {31'd0, mem_req_valid}, 32'd0);
    chk("fl_drain_stall1", {31'd0, stall_out}, 32'd1);
    step();
    chk("fl_drain_stall2", {31'd0, stall_out}, 32'd1);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    #1;
    chk("fl_drain_stall3", {31'd0, stall_out}, 32'd1);
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #1;
    chk("fl_stall_end", {31'd0, stall_out}, 32'd0);
    chk("fl_discard", read_data_out, 32'hFFFF_FF80);
    chk("fl_valid_end", {31'd0, valid_out}, 32'd0);

    // completed load then stall_in held: no re-issue
    hs = 0;
    issue(32'h0000_3000, 32'd0, 5'd4, 1'b1, FROM_CACHE, 1'b0, SIZE_W, NO_XCPT);
    step();
    clear_in();
    stall_in = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    #1;
    chk("st_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("st_stall", {31'd0, stall_out}, 32'd0);
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("st_noreissue_%0d", i), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("st_read_%0d", i), read_data_out, 32'hCAFE_F00D);
      chk($sformatf("st_held_%0d", i), {31'd0, valid_out}, 32'd1);
      step();
    end
    chk("st_handshakes", hs, 32'd1);

    // flush beats stall
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; stall_in = 1'b0;
    #1;
    chk("fs_valid_out", {31'd0, valid_out}, 32'd0);
    chk("fs_rd_out", {27'd0, rd_out}, 32'd0);
    chk("fs_read_kept", read_data_out, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
